// File: rtl/operand_forward_ctrl.sv
// operand_forward_ctrl
//
// Hazard and forwarding controller for the SPARC integer pipeline.
// Keeps a three-entry shadow of the destination registers of the
// instructions sitting in EX, MEM and WB, and from it derives:
//   - the 2-bit selects of the two operand mux_4x1 instances
//     (00 = register file, 01 = EX result, 10 = MEM result, 11 = WB result)
//   - a stall / bubble pair for load-use hazards and memory wait.
//
// Optional feature macro: FWD_WB_EN
//   defined   : a WB-only match forwards through select 2'b11.
//   undefined : 2'b11 is never produced; a WB-only match on a used source of
//               a live ID instruction costs one stall/bubble cycle, after
//               which the register file holds the value and 2'b00 is used.
//
// Handshake semantics: this block has no valid/ready channel. id_valid
// qualifies the ID inputs for one cycle; stall means "the ID instruction did
// not advance this cycle, present it again"; bubble means "ID/EX loads a NOP
// this cycle". mem_busy freezes the whole pipeline, including the shadow.
//
// All outputs are combinational from the shadow state and the ID inputs.
// While mem_busy is high the shadow is frozen and the pipeline holds the
// ID instruction, so the selects hold their values without extra storage.

module operand_forward_ctrl #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic             mem_busy,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic             bubble
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // ------------------------------------------------------------------
    // Shadow state. Only the EX entry needs is_load: a load's result
    // exists from MEM onward, so later stages forward like any ALU op.
    // ------------------------------------------------------------------
    logic [REG_W-1:0] ex_rd;
    logic             ex_we;
    logic             ex_ld;
    logic [REG_W-1:0] mem_rd;
    logic             mem_we;
    logic [REG_W-1:0] wb_rd;
    logic             wb_we;

    // ID instruction is real and not being killed this cycle
    logic id_live;

    // per-stage match flags for each source
    logic a_ex, a_mem, a_wb;
    logic b_ex, b_mem, b_wb;

    // priority-resolved select before hazard masking
    logic [1:0] raw_a, raw_b;

    // hazard contributions
    logic lu_a, lu_b;     // load in EX feeds this source
    logic wbh_a, wbh_b;   // WB-only match with no WB forwarding path
    logic hazard;

    // A shadow entry matches a source only if it writes a register other
    // than %g0; %g0 reads therefore always fall through to the register file.
    function automatic logic hit(input logic             we,
                                 input logic [REG_W-1:0] rd,
                                 input logic [REG_W-1:0] src);
        return we && (rd == src) && (rd != '0);
    endfunction

    assign id_live = id_valid & ~flush;

    assign a_ex  = hit(ex_we,  ex_rd,  id_rs1);
    assign a_mem = hit(mem_we, mem_rd, id_rs1);
    assign a_wb  = hit(wb_we,  wb_rd,  id_rs1);
    assign b_ex  = hit(ex_we,  ex_rd,  id_rs2);
    assign b_mem = hit(mem_we, mem_rd, id_rs2);
    assign b_wb  = hit(wb_we,  wb_rd,  id_rs2);

    // Youngest producer wins for operand A: EX, then MEM, then WB
    always_comb begin
        raw_a = SEL_RF;
        if (id_rs1_used) begin
            if (a_ex)       raw_a = SEL_EX;
            else if (a_mem) raw_a = SEL_MEM;
            else if (a_wb)  raw_a = SEL_WB;
        end
    end

    // Youngest producer wins for operand B: EX, then MEM, then WB
    always_comb begin
        raw_b = SEL_RF;
        if (id_rs2_used) begin
            if (b_ex)       raw_b = SEL_EX;
            else if (b_mem) raw_b = SEL_MEM;
            else if (b_wb)  raw_b = SEL_WB;
        end
    end

    // A load in EX has no result yet; a live consumer must wait one cycle.
    // A flushed ID instruction never raises a hazard.
    assign lu_a = id_live & id_rs1_used & a_ex & ex_ld;
    assign lu_b = id_live & id_rs2_used & b_ex & ex_ld;

`ifdef FWD_WB_EN
    assign wbh_a = 1'b0;
    assign wbh_b = 1'b0;
`else
    // Without the WB path, wait one cycle for the register file write.
    assign wbh_a = id_live & (raw_a == SEL_WB);
    assign wbh_b = id_live & (raw_b == SEL_WB);
`endif

    assign hazard = lu_a | lu_b | wbh_a | wbh_b;

    // Final operand-A select: sources under hazard read the register file
    always_comb begin
        fwd_a_sel = raw_a;
        if (lu_a) fwd_a_sel = SEL_RF;
`ifndef FWD_WB_EN
        if (raw_a == SEL_WB) fwd_a_sel = SEL_RF;
`endif
    end

    // Final operand-B select: sources under hazard read the register file
    always_comb begin
        fwd_b_sel = raw_b;
        if (lu_b) fwd_b_sel = SEL_RF;
`ifndef FWD_WB_EN
        if (raw_b == SEL_WB) fwd_b_sel = SEL_RF;
`endif
    end

    // Memory wait freezes everything and suppresses the bubble so the
    // hazard is re-evaluated once the freeze lifts. Both outputs are forced
    // low while reset is asserted, so a stall drops as soon as reset does.
    always_comb begin
        stall  = reset_n & (mem_busy | hazard);
        bubble = reset_n & hazard & ~mem_busy;
    end

    // Shadow advance: WB <- MEM <- EX <- ID (or NOP when bubbling);
    // frozen while memory is busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_rd  <= '0;
            ex_we  <= 1'b0;
            ex_ld  <= 1'b0;
            mem_rd <= '0;
            mem_we <= 1'b0;
            wb_rd  <= '0;
            wb_we  <= 1'b0;
        end else if (!mem_busy) begin
            wb_rd  <= mem_rd;
            wb_we  <= mem_we;
            mem_rd <= ex_rd;
            mem_we <= ex_we;
            if (bubble) begin
                ex_rd <= '0;
                ex_we <= 1'b0;
                ex_ld <= 1'b0;
            end else begin
                ex_rd <= id_rd;
                ex_we <= id_rd_we & id_live;
                ex_ld <= id_is_load & id_live;
            end
        end
    end

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Testbench for operand_forward_ctrl. Directed scenarios with literal
// expectations, then a randomized run checked against an in-bench model
// that tracks in-flight instructions as a youngest-first list.
// Honours FWD_WB_EN the same way the design does.

module tb_operand_forward_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
    logic       mem_busy, flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, bubble;

    int n_vec  = 0;
    int n_fail = 0;

    // reference model: in-flight list, index 0 = youngest (EX)
    logic [4:0] m_rd[3];
    logic       m_we[3];
    logic       m_ld[3];
    logic [1:0] e_a, e_b;
    logic       e_stall, e_bubble;

    operand_forward_ctrl #(.REG_W(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rd_we    (id_rd_we),
        .id_is_load  (id_is_load),
        .mem_busy    (mem_busy),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall),
        .bubble      (bubble)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic ld);
        id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd; id_rd_we = we; id_is_load = ld;
    endtask

    task automatic set_idle;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        mem_busy = 1'b0;
        flush    = 1'b0;
    endtask

    // inputs change at edge+1, outputs sampled at edge+4
    task automatic settle;
        #3;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        set_idle;
        reset_n = 1'b0;
        step;
        reset_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    function automatic int youngest(input logic [4:0] r, input logic used);
        if (!used || r == 5'd0) return -1;
        for (int i = 0; i < 3; i++)
            if (m_we[i] && m_rd[i] == r) return i;
        return -1;
    endfunction

    task automatic model_clear;
        for (int i = 0; i < 3; i++) begin
            m_rd[i] = 5'd0; m_we[i] = 1'b0; m_ld[i] = 1'b0;
        end
    endtask

    task automatic model_eval;
        int   ia, ib;
        logic live, haz;
        live = id_valid && !flush;
        haz  = 1'b0;
        ia = youngest(id_rs1, id_rs1_used);
        ib = youngest(id_rs2, id_rs2_used);
        e_a = (ia < 0) ? 2'd0 : 2'(ia + 1);
        e_b = (ib < 0) ? 2'd0 : 2'(ib + 1);
        if (ia == 0 && m_ld[0] && live) begin haz = 1'b1; e_a = 2'd0; end
        if (ib == 0 && m_ld[0] && live) begin haz = 1'b1; e_b = 2'd0; end
`ifndef FWD_WB_EN
        if (ia == 2) begin e_a = 2'd0; if (live) haz = 1'b1; end
        if (ib == 2) begin e_b = 2'd0; if (live) haz = 1'b1; end
`endif
        e_stall  = mem_busy || haz;
        e_bubble = haz && !mem_busy;
    endtask

    task automatic model_clock;
        logic live;
        live = id_valid && !flush;
        if (!mem_busy) begin
            for (int i = 2; i > 0; i--) begin
                m_rd[i] = m_rd[i-1]; m_we[i] = m_we[i-1]; m_ld[i] = m_ld[i-1];
            end
            if (e_bubble) begin
                m_rd[0] = 5'd0; m_we[0] = 1'b0; m_ld[0] = 1'b0;
            end else begin
                m_rd[0] = id_rd; m_we[0] = id_rd_we && live; m_ld[0] = id_is_load && live;
            end
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset;
        set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1);
        mem_busy = 1'b1;
        reset_n  = 1'b0;
        #2;
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b00_00_0_0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b00_00_0_0);
        end
        step;
        do_reset;
    endtask

    task automatic test_ex_forward;
        do_reset;
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);   // add r3 <- r1,r2
        settle;
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b00_00_0_0) begin
            n_fail++;
            $display("FAIL add_issue: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b00_00_0_0);
        end
        step;
        set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);   // sub r4 <- r3,r3
        settle;
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b01_01_0_0) begin
            n_fail++;
            $display("FAIL sub_ex_fwd: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b01_01_0_0);
        end
        step;
    endtask

    task automatic test_load_use;
        do_reset;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // ld r5
        step;
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);   // add r6 <- r5,r0
        settle;
        n_vec++;
        if ({stall, bubble} !== 2'b11) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b want %b", {stall, bubble}, 2'b11);
        end
        step;
        settle;
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b10_00_0_0) begin
            n_fail++;
            $display("FAIL load_use_release: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b10_00_0_0);
        end
        step;
    endtask

    task automatic test_youngest_wins;
        do_reset;
        repeat (3) begin
            set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
            step;
        end
        set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        settle;
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b01_01_0_0) begin
            n_fail++;
            $display("FAIL youngest_ex: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b01_01_0_0);
        end
        step;
        // EX now holds r8; r7 in MEM and WB -> MEM wins
        set_id(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        settle;
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b10_01_0_0) begin
            n_fail++;
            $display("FAIL mem_over_wb: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b10_01_0_0);
        end
        step;
    endtask

    task automatic test_mem_busy;
        do_reset;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // ld r5
        step;
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        mem_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle;
            n_vec++;
            if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b00_00_1_0) begin
                n_fail++;
                $display("FAIL busy_freeze[%0d]: got %b want %b", c, {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b00_00_1_0);
            end
            step;
        end
        mem_busy = 1'b0;
        settle;
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b00_00_1_1) begin
            n_fail++;
            $display("FAIL busy_then_bubble: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b00_00_1_1);
        end
        step;
        settle;
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b10_00_0_0) begin
            n_fail++;
            $display("FAIL busy_after_bubble: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b10_00_0_0);
        end
        // async reset during a memory stall
        mem_busy = 1'b1;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_stall: got %b want %b", stall, 1'b1);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({stall, bubble} !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_stall: got %b want %b", {stall, bubble}, 2'b00);
        end
        step;
        mem_busy = 1'b0;
        reset_n  = 1'b1;
    endtask

    task automatic test_flush;
        do_reset;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // ld r5
        step;
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);   // add r6 <- r5, flushed
        flush = 1'b1;
        settle;
        n_vec++;
        if ({stall, bubble} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_no_stall: got %b want %b", {stall, bubble}, 2'b00);
        end
        step;
        flush = 1'b0;
        set_id(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);
        settle;
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b00_10_0_0) begin
            n_fail++;
            $display("FAIL flush_killed_we: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b00_10_0_0);
        end
        step;
    endtask

    task automatic test_r0;
        do_reset;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);   // write r0
        step;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // load to r0
        step;
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0);
        settle;
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b00_00_0_0) begin
            n_fail++;
            $display("FAIL r0_reads: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b00_00_0_0);
        end
        step;
    endtask

    task automatic test_wb_path;
        do_reset;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);   // write r9
        step;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step;
        step;
        set_id(1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0);
        settle;
`ifdef FWD_WB_EN
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b11_00_0_0) begin
            n_fail++;
            $display("FAIL wb_forward: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b11_00_0_0);
        end
        step;
`else
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b00_00_1_1) begin
            n_fail++;
            $display("FAIL wb_hazard: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b00_00_1_1);
        end
        step;
        settle;
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== 6'b00_00_0_0) begin
            n_fail++;
            $display("FAIL wb_after_stall: got %b want %b", {fwd_a_sel, fwd_b_sel, stall, bubble}, 6'b00_00_0_0);
        end
        step;
`endif
    endtask

    task automatic test_random;
        logic prev_stall;
        do_reset;
        model_clear;
        prev_stall = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!prev_stall) begin
                id_valid    = ($urandom_range(0, 99) < 85);
                id_rs1      = 5'($urandom_range(0, 7));
                id_rs2      = 5'($urandom_range(0, 7));
                id_rs1_used = ($urandom_range(0, 99) < 80);
                id_rs2_used = ($urandom_range(0, 99) < 60);
                id_rd       = 5'($urandom_range(0, 7));
                id_rd_we    = ($urandom_range(0, 99) < 80);
                id_is_load  = ($urandom_range(0, 99) < 25);
            end
            mem_busy = ($urandom_range(0, 99) < 15);
            flush    = ($urandom_range(0, 99) < 8);
            settle;
            model_eval;
            n_vec++;
            if ({fwd_a_sel, fwd_b_sel, stall, bubble} !== {e_a, e_b, e_stall, e_bubble}) begin
                n_fail++;
                $display("FAIL random[%0d]: got a=%b b=%b st=%b bu=%b want a=%b b=%b st=%b bu=%b",
                         n, fwd_a_sel, fwd_b_sel, stall, bubble, e_a, e_b, e_stall, e_bubble);
            end
            prev_stall = e_stall;
            model_clock;
            step;
        end
        set_idle;
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        set_idle;
        reset_n = 1'b0;
        #1;
        test_reset;
        test_ex_forward;
        test_load_use;
        test_youngest_wins;
        test_mem_busy;
        test_flush;
        test_r0;
        test_wb_path;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
